// File: rtl/fir_stage.sv
// Three-tap FIR stage: accepts one 10-bit sample per idle visit, multiplies and accumulates
// one tap per cycle, then emits a shifted, saturated 10-bit result with a one-cycle strobe.
module fir_stage #(
  parameter int unsigned SHIFT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [9:0]  in_sample,
  input  logic [29:0] coeffs,
  output logic        in_ready,
  output logic        out_valid,
  output logic [9:0]  filtered,
  output logic        overrun
);

  localparam int unsigned AccW = 24;

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             k_q, k_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [9:0]             x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
  logic [29:0]            coef_q, coef_d;
  logic [9:0]             filtered_q, filtered_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q, overrun_d;

  logic [9:0]             tap_coef_raw;
  logic [9:0]             tap_x_raw;
  logic signed [20:0]     tap_coef;
  logic signed [20:0]     tap_x;
  logic signed [20:0]     product;
  logic signed [AccW-1:0] shifted;

  // Tap select for the current MAC step.
  always_comb begin
    tap_coef_raw = coef_q[9:0];
    tap_x_raw    = x0_q;
    unique case (k_q)
      2'd0: begin
        tap_coef_raw = coef_q[9:0];
        tap_x_raw    = x0_q;
      end
      2'd1: begin
        tap_coef_raw = coef_q[19:10];
        tap_x_raw    = x1_q;
      end
      default: begin
        tap_coef_raw = coef_q[29:20];
        tap_x_raw    = x2_q;
      end
    endcase
  end

  // |c*x| <= 512*1023 fits in 21 signed bits, so the truncated product is exact.
  assign tap_coef = {{11{tap_coef_raw[9]}}, tap_coef_raw};
  assign tap_x    = {11'b0, tap_x_raw};
  assign product  = tap_coef * tap_x;
  assign shifted  = acc_q >>> SHIFT;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    coef_d      = coef_q;
    filtered_d  = filtered_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;

    if (in_valid && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x2_d    = x1_q;
          x1_d    = x0_q;
          x0_d    = in_sample;
          coef_d  = coeffs;
          acc_d   = '0;
          k_d     = 2'd0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + {{(AccW - 21){product[20]}}, product};
        if (k_q == 2'd2) begin
          k_d     = 2'd0;
          state_d = StOut;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      StOut: begin
        if (shifted[AccW-1]) begin
          filtered_d = 10'd0;
        end else if (|shifted[AccW-2:10]) begin
          filtered_d = 10'd1023;
        end else begin
          filtered_d = shifted[9:0];
        end
        out_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      k_q         <= 2'd0;
      acc_q       <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      coef_q      <= '0;
      filtered_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      coef_q      <= coef_d;
      filtered_q  <= filtered_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign filtered  = filtered_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/fir_stage.md
FIR_STAGE -- requirements
Module: fir_stage

Interface
REQ-001 SHALL have parameter SHIFT, default 8, meaning the arithmetic right-shift applied to the accumulator before output.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: new-sample strobe from the SPI receive stage, synchronous to clk.
REQ-005 SHALL have port in_sample, input, 10 bits: unsigned ADC voltage sample (0..1023).
REQ-006 SHALL have port coeffs, input, 30 bits: three signed two's-complement taps, c0=[9:0], c1=[19:10], c2=[29:20].
REQ-007 SHALL have port in_ready, output, 1 bit: high when a sample can be accepted.
REQ-008 SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new filtered value.
REQ-009 SHALL have port filtered, output, 10 bits: unsigned saturated filter output.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag marking a dropped sample.

Function
REQ-011 SHALL hold a 3-entry sample delay line x0 (newest), x1, x2, each 10 bits.
REQ-012 SHALL implement FSM states IDLE, MAC, OUT, using a 2-bit tap index k inside MAC.
REQ-013 SHALL drive in_ready=1 only in IDLE.
REQ-014 SHALL accept a sample at a rising edge where in_valid=1 and state=IDLE.
- On accept: x2<=x1, x1<=x0, x0<=in_sample.
- coeffs latched into internal registers.
- Accumulator cleared; k<=0; state<=MAC.
REQ-015 SHALL in MAC add ck * xk to the accumulator each cycle for k=0,1,2.
- Each sample is zero-extended to 11-bit signed before multiplying.
- After k=2, state<=OUT.
REQ-016 SHALL use a signed accumulator of at least 24 bits, so that no intermediate overflow is possible.
REQ-017 SHALL in OUT register filtered = clamp(acc >>> SHIFT, 0, 1023), pulse out_valid for exactly one cycle, and return to IDLE.
REQ-018 SHALL give fixed latency: accept edge N, MACs on edges N+1..N+3, filtered/out_valid updated on edge N+4, in_ready high again after edge N+4.
REQ-019 SHALL hold filtered stable between out_valid pulses.
REQ-020 SHALL ignore in_valid when in_ready=0.
- Delay line and coeffs remain unchanged.
- overrun is set to 1 and stays at 1 until reset.
REQ-021 SHALL use only the coefficients latched at acceptance; coeffs changes during MAC/OUT have no effect on the current result.
REQ-022 SHALL treat in_valid held high across several idle cycles as one sample per IDLE visit; every held cycle outside IDLE sets overrun.

Reset
REQ-023 SHALL on reset asynchronously force: state=IDLE, k=0, accumulator=0, x0=x1=x2=0, latched coeffs=0, filtered=0, out_valid=0, overrun=0; in_ready=1 follows from state=IDLE.
REQ-024 SHALL on reset during MAC or OUT abandon the computation, emit no out_valid pulse, and apply the clear of REQ-023.
REQ-025 SHALL resume normal acceptance on the first rising edge after reset deasserts.

Verification
REQ-026 Reset: assert reset -> filtered=0, out_valid=0, in_ready=1, overrun=0.
REQ-027 Identity: coeffs c0=256, c1=0, c2=0; in_sample=500 accepted at edge N -> filtered=500 with out_valid pulse at edge N+4.
REQ-028 Moving average: c0=c1=c2=85; samples 300, 300, 300 -> outputs 99, 199, 298.
REQ-029 Saturation:
- c0=511, sample 1023 -> filtered=1023.
- c0=-256 (0x300), sample 100 -> filtered=0.
REQ-030 Overrun: pulse in_valid at edge N with sample 400, pulse again at N+2 with sample 700 (c0=256) -> filtered=400, overrun=1, x0 still 400.
REQ-031 Reset mid-MAC: accept 600 at N with c0=c1=256, assert reset at N+2 -> no out_valid; then accept 200 -> filtered=200, since x1 was cleared.
